// File: rtl/mem_pkg.sv
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared funct3 encodings and MMIO register offsets for the
//                CPU data-memory responder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] OFF_CYCLE_LO = 4'h0;
    localparam logic [3:0] OFF_CYCLE_HI = 4'h4;
    localparam logic [3:0] OFF_TOHOST   = 4'h8;
    localparam logic [3:0] OFF_ERR      = 4'hC;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module      : mem_lane_align
//  Description : Byte-lane steering for stores and extraction/extension for
//                loads, with alignment and funct3 legality checks.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] st_data,
    output logic        st_fault,
    output logic [31:0] ld_data,
    output logic        ld_ok
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: replicate data across lanes so only the enable needs shifting.
    always_comb begin
        byte_en  = 4'b0000;
        st_data  = 32'd0;
        st_fault = 1'b1;
        case (funct3)
            F3_B: begin
                byte_en  = 4'b0001 << addr_lo;
                st_data  = {4{write_data[7:0]}};
                st_fault = 1'b0;
            end
            F3_H: begin
                if (!addr_lo[0]) begin
                    byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                    st_data  = {2{write_data[15:0]}};
                    st_fault = 1'b0;
                end
            end
            F3_W: begin
                if (addr_lo == 2'b00) begin
                    byte_en  = 4'b1111;
                    st_data  = write_data;
                    st_fault = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = 8'd0;
        case (addr_lo)
            2'd0:    w_byte = rd_word[7:0];
            2'd1:    w_byte = rd_word[15:8];
            2'd2:    w_byte = rd_word[23:16];
            default: w_byte = rd_word[31:24];
        endcase
        w_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        ld_data = 32'd0;
        ld_ok   = 1'b0;
        case (funct3)
            F3_B: begin
                ld_data = {{24{w_byte[7]}}, w_byte};
                ld_ok   = 1'b1;
            end
            F3_BU: begin
                ld_data = {24'd0, w_byte};
                ld_ok   = 1'b1;
            end
            F3_H: begin
                if (!addr_lo[0]) begin
                    ld_data = {{16{w_half[15]}}, w_half};
                    ld_ok   = 1'b1;
                end
            end
            F3_HU: begin
                if (!addr_lo[0]) begin
                    ld_data = {16'd0, w_half};
                    ld_ok   = 1'b1;
                end
            end
            F3_W: begin
                if (addr_lo == 2'b00) begin
                    ld_data = rd_word;
                    ld_ok   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module      : data_mem_responder
//  Description : CPU data-memory responder: byte-lane RAM plus an MMIO window
//                holding a cycle counter, TOHOST mailbox and store-fault flag.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] addr,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misalign_err,
    output logic [31:0] err_addr,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);

    localparam int          c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] c_RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0] r_ram [DEPTH_WORDS];

    logic [63:0] r_cycle;
    logic        r_misalign_err;
    logic [31:0] r_err_addr;
    logic        r_tohost_valid;
    logic [31:0] r_tohost_data;

    logic               w_in_ram;
    logic               w_in_mmio;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rd_word;
    logic [3:0]         w_byte_en;
    logic [31:0]        w_st_data;
    logic               w_st_fault;
    logic [31:0]        w_ld_data;
    logic               w_ld_ok;
    logic               w_st_ok;
    logic               w_mmio_word_acc;
    logic [31:0]        w_mmio_rd;

    assign w_in_ram  = ({1'b0, addr} < c_RAM_BYTES);
    assign w_in_mmio = (addr[31:4] == MMIO_BASE[31:4]);
    assign w_idx     = addr[c_IDX_W+1:2];
    assign w_rd_word = w_in_ram ? r_ram[w_idx] : 32'd0;

    mem_lane_align u_lane_align (
        .addr_lo    (addr[1:0]),
        .funct3     (funct3),
        .write_data (write_data),
        .rd_word    (w_rd_word),
        .byte_en    (w_byte_en),
        .st_data    (w_st_data),
        .st_fault   (w_st_fault),
        .ld_data    (w_ld_data),
        .ld_ok      (w_ld_ok)
    );

    assign w_st_ok         = mem_write && !w_st_fault;
    assign w_mmio_word_acc = (funct3 == F3_W) && (addr[1:0] == 2'b00);

    always_comb begin
        w_mmio_rd = 32'd0;
        case (addr[3:0])
            OFF_CYCLE_LO: w_mmio_rd = r_cycle[31:0];
            OFF_CYCLE_HI: w_mmio_rd = r_cycle[63:32];
            OFF_TOHOST:   w_mmio_rd = r_tohost_data;
            OFF_ERR:      w_mmio_rd = {31'd0, r_misalign_err};
            default:      w_mmio_rd = 32'd0;
        endcase
    end

    always_comb begin
        read_data = 32'd0;
        if (w_in_ram && w_ld_ok) begin
            read_data = w_ld_data;
        end else if (w_in_mmio && w_mmio_word_acc) begin
            read_data = w_mmio_rd;
        end
    end

    // RAM has no reset, so a store coinciding with Reset still lands.
    always_ff @(posedge clk) begin
        if (w_st_ok && w_in_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    r_ram[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_cycle        <= 64'd0;
            r_misalign_err <= 1'b0;
            r_err_addr     <= 32'd0;
            r_tohost_valid <= 1'b0;
            r_tohost_data  <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (mem_write && w_st_fault) begin
                r_misalign_err <= 1'b1;
                if (!r_misalign_err) begin
                    r_err_addr <= addr;
                end
            end else if (w_st_ok && w_in_mmio && w_mmio_word_acc) begin
                case (addr[3:0])
                    OFF_TOHOST: begin
                        r_tohost_valid <= 1'b1;
                        r_tohost_data  <= write_data;
                    end
                    OFF_ERR: begin
                        r_misalign_err <= 1'b0;
                        r_err_addr     <= 32'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign misalign_err = r_misalign_err;
    assign err_addr     = r_err_addr;
    assign tohost_valid = r_tohost_valid;
    assign tohost_data  = r_tohost_data;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Scoreboard bench for data_mem_responder against a byte-level
//                reference model of memory, MMIO registers and counter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MB    = 32'hFFFF_0000;
    localparam logic [31:0] RAMB  = 32'(4 * DEPTH);

    logic        clk;
    logic        Reset;
    logic [31:0] addr;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        misalign_err;
    logic [31:0] err_addr;
    logic        tohost_valid;
    logic [31:0] tohost_data;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (MB)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .addr         (addr),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .write_data   (write_data),
        .read_data    (read_data),
        .misalign_err (misalign_err),
        .err_addr     (err_addr),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic [31:0] ea;
        logic        tv;
        logic [31:0] td;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [7:0]  m_mem [0:4*DEPTH-1];
    logic [63:0] m_cnt;
    logic        m_err;
    logic [31:0] m_ea;
    logic        m_tv;
    logic [31:0] m_td;

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int          size;
        logic [63:0] v;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 32'd0;
        size = acc_size(f3);
        if ((a & 32'(size - 1)) != 32'd0) return 32'd0;
        if (a < RAMB) begin
            v = 64'd0;
            for (int i = 0; i < size; i++) v = v | (64'(m_mem[a + 32'(i)]) << (8 * i));
            if (!f3[2] && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
            return v[31:0];
        end
        if (a[31:4] == MB[31:4]) begin
            if (f3 != 3'd2) return 32'd0;
            case (a[3:0])
                4'h0:    return m_cnt[31:0];
                4'h4:    return m_cnt[63:32];
                4'h8:    return m_td;
                4'hC:    return {31'd0, m_err};
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3,
                               input logic [31:0] wd, input bit rst);
        int size;
        bit legal;
        legal = (f3 inside {3'd0, 3'd1, 3'd2});
        size  = acc_size(f3);
        if (!legal || ((a & 32'(size - 1)) != 32'd0)) begin
            if (!rst) begin
                if (!m_err) m_ea = a;
                m_err = 1'b1;
            end
        end else if (a < RAMB) begin
            for (int i = 0; i < size; i++) m_mem[a + 32'(i)] = wd[8*i +: 8];
        end else if (a[31:4] == MB[31:4] && f3 == 3'd2 && !rst) begin
            if (a[3:0] == 4'h8) begin
                m_tv = 1'b1;
                m_td = wd;
            end else if (a[3:0] == 4'hC) begin
                m_err = 1'b0;
                m_ea  = 32'd0;
            end
        end
    endtask

    // One cycle of stimulus; cc forces a literal expected read value.
    task automatic op(input bit rst, input bit we, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input bit cc = 1'b0, input logic [31:0] cv = 32'd0);
        exp_t e;
        @(posedge clk);
        #1;
        Reset      = rst;
        mem_write  = we;
        addr       = a;
        funct3     = f3;
        write_data = wd;
        e.rd = cc ? cv : model_load(a, f3);
        e.err = m_err;
        e.ea  = m_ea;
        e.tv  = m_tv;
        e.td  = m_td;
        q.push_back(e);
        if (we) model_store(a, f3, wd, rst);
        if (rst) begin
            m_cnt = 64'd0;
            m_err = 1'b0;
            m_ea  = 32'd0;
            m_tv  = 1'b0;
            m_td  = 32'd0;
        end else begin
            m_cnt = m_cnt + 64'd1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("read_data", read_data, e.rd);
            check("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
            check("err_addr", err_addr, e.ea);
            check("tohost_valid", {31'd0, tohost_valid}, {31'd0, e.tv});
            check("tohost_data", tohost_data, e.td);
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        bit          we;
        int          r;

        Reset = 1'b1; mem_write = 1'b0; addr = 32'd0; funct3 = 3'd2; write_data = 32'd0;
        m_cnt = 64'd0; m_err = 1'b0; m_ea = 32'd0; m_tv = 1'b0; m_td = 32'd0;
        for (int i = 0; i < 4 * DEPTH; i++) m_mem[i] = 8'd0;

        repeat (3) op(1'b1, 1'b0, 32'd0, 3'd2, 32'd0);
        for (int w = 0; w < 10; w++) op(1'b0, 1'b1, 32'(4 * w), 3'd2, $urandom);
        op(1'b0, 1'b0, MB + 32'h0, 3'd2, 32'd0, 1'b1, 32'd10);
        op(1'b0, 1'b0, MB + 32'h4, 3'd2, 32'd0, 1'b1, 32'd0);
        for (int w = 10; w < 64; w++) op(1'b0, 1'b1, 32'(4 * w), 3'd2, $urandom);
        for (int w = 0; w < 4; w++) op(1'b0, 1'b1, RAMB - 32'd16 + 32'(4 * w), 3'd2, $urandom);

        op(1'b0, 1'b1, 32'h10, 3'd2, 32'h8000_00F1);
        op(1'b0, 1'b0, 32'h10, 3'd0, 32'd0, 1'b1, 32'hFFFF_FFF1);
        op(1'b0, 1'b0, 32'h10, 3'd4, 32'd0, 1'b1, 32'h0000_00F1);
        op(1'b0, 1'b0, 32'h10, 3'd1, 32'd0, 1'b1, 32'h0000_00F1);
        op(1'b0, 1'b0, 32'h10, 3'd5, 32'd0, 1'b1, 32'h0000_00F1);
        op(1'b0, 1'b0, 32'h10, 3'd2, 32'd0, 1'b1, 32'h8000_00F1);
        op(1'b0, 1'b1, 32'h13, 3'd0, 32'h0000_00AB);
        op(1'b0, 1'b1, 32'h10, 3'd1, 32'h0000_1234);
        op(1'b0, 1'b0, 32'h10, 3'd2, 32'd0, 1'b1, 32'hAB00_1234);
        op(1'b0, 1'b0, 32'h13, 3'd0, 32'd0, 1'b1, 32'hFFFF_FFAB);

        op(1'b0, 1'b1, 32'h21, 3'd1, 32'h0000_BEEF);
        op(1'b0, 1'b0, 32'h20, 3'd2, 32'd0);
        op(1'b0, 1'b1, 32'h22, 3'd2, 32'h1111_2222);
        op(1'b0, 1'b0, MB + 32'hC, 3'd2, 32'd0, 1'b1, 32'd1);
        op(1'b0, 1'b1, MB + 32'hC, 3'd2, 32'h5A5A_5A5A);
        op(1'b0, 1'b0, MB + 32'hC, 3'd2, 32'd0, 1'b1, 32'd0);

        op(1'b0, 1'b1, MB + 32'h8, 3'd2, 32'd1);
        op(1'b0, 1'b0, MB + 32'h8, 3'd2, 32'd0, 1'b1, 32'd1);
        op(1'b0, 1'b1, MB + 32'h8, 3'd0, 32'h55);
        op(1'b0, 1'b0, MB + 32'h8, 3'd2, 32'd0, 1'b1, 32'd1);
        op(1'b0, 1'b1, MB + 32'h0, 3'd2, 32'hDEAD_0000);

        op(1'b0, 1'b1, RAMB, 3'd2, 32'h7777_7777);
        op(1'b0, 1'b0, RAMB, 3'd2, 32'd0, 1'b1, 32'd0);
        op(1'b1, 1'b1, 32'h0, 3'd2, 32'hCAFE_F00D);
        op(1'b0, 1'b0, 32'h0, 3'd2, 32'd0, 1'b1, 32'hCAFE_F00D);

        for (int n = 0; n < 2000; n++) begin
            r  = $urandom_range(0, 9);
            we = ($urandom_range(0, 2) == 0);
            f3 = 3'($urandom_range(0, 7));
            if (r <= 5) begin
                a = 32'($urandom_range(0, 255));
            end else if (r == 6) begin
                a = RAMB - 32'd16 + 32'($urandom_range(0, 15));
            end else if (r <= 8) begin
                a = MB + 32'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    f3 = 3'd2;
                    a[1:0] = 2'b00;
                end
            end else begin
                a = RAMB + 32'($urandom_range(0, 15));
                if (we) begin
                    f3 = 3'd2;
                    a[1:0] = 2'b00;
                end
            end
            op(($urandom_range(0, 99) == 0), we, a, f3, $urandom);
        end

        @(posedge clk);
        #1;
        Reset = 1'b0; mem_write = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
